// File: rtl/calc_operand_loader.sv
// calc_operand_loader: operand-entry stage feeding the 8-bit adder.
// Enter presses load operand A, then operand B, and then hold both with
// operands_valid. Clear returns the block to A entry and has priority.
// Optional feature macro: CALC_DEBOUNCE_EN builds the enter debouncer.
// Without it, the synchronized enter level is used directly (fast simulation).
module calc_operand_loader #(
  parameter int WIDTH           = 8,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] sw,
  input  logic             btn_enter,
  input  logic             btn_clear,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic             operands_valid,
  output logic [1:0]       entry_state
);

  typedef enum logic [1:0] {
    GET_A = 2'b00,
    GET_B = 2'b01,
    READY = 2'b10
  } state_t;

  logic [1:0]            enter_sync;
  logic [1:0]            clear_sync;
  logic [1:0][WIDTH-1:0] sw_sync;
  logic                  enter_s;
  logic                  clear_s;
  logic [WIDTH-1:0]      sw_s;
  logic                  enter_db;
  logic                  enter_db_d;
  logic                  enter_pulse;

  state_t                state_q, state_d;
  logic [WIDTH-1:0]      a_d, b_d;
  logic                  valid_d;

  // Two-flop synchronizers for every asynchronous input.
  always_ff @(posedge clk) begin
    if (rst) begin
      enter_sync <= '0;
      clear_sync <= '0;
      sw_sync    <= '0;
    end else begin
      enter_sync <= {enter_sync[0], btn_enter};
      clear_sync <= {clear_sync[0], btn_clear};
      sw_sync    <= {sw_sync[0], sw};
    end
  end

  assign enter_s = enter_sync[1];
  assign clear_s = clear_sync[1];
  assign sw_s    = sw_sync[1];

`ifdef CALC_DEBOUNCE_EN
  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic [CNT_W-1:0] db_cnt;

  // Accept a new enter level only after it has disagreed with the held
  // level for DEBOUNCE_CYCLES consecutive cycles; any agreement restarts.
  always_ff @(posedge clk) begin
    if (rst) begin
      db_cnt   <= '0;
      enter_db <= 1'b0;
    end else if (enter_s == enter_db) begin
      db_cnt   <= '0;
    end else if (db_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
      db_cnt   <= '0;
      enter_db <= enter_s;
    end else begin
      db_cnt   <= db_cnt + CNT_W'(1);
    end
  end
`else
  assign enter_db = enter_s;
`endif

  // Delayed debounced level for rising-edge detection.
  always_ff @(posedge clk) begin
    if (rst) enter_db_d <= 1'b0;
    else     enter_db_d <= enter_db;
  end

  // One pulse per accepted press; a held button never repeats.
  assign enter_pulse = enter_db & ~enter_db_d;

  // State and operand registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= GET_A;
      a              <= '0;
      b              <= '0;
      operands_valid <= 1'b0;
    end else begin
      state_q        <= state_d;
      a              <= a_d;
      b              <= b_d;
      operands_valid <= valid_d;
    end
  end

  // Next-state and operand loads; clear outranks enter in every state.
  always_comb begin
    state_d = state_q;
    a_d     = a;
    b_d     = b;
    valid_d = operands_valid;
    if (clear_s) begin
      state_d = GET_A;
      a_d     = '0;
      b_d     = '0;
      valid_d = 1'b0;
    end else if (enter_pulse) begin
      case (state_q)
        GET_A: begin
          a_d     = sw_s;
          state_d = GET_B;
        end
        GET_B: begin
          b_d     = sw_s;
          valid_d = 1'b1;
          state_d = READY;
        end
        READY: begin
          // New calculation: B keeps its old value until reloaded.
          a_d     = sw_s;
          valid_d = 1'b0;
          state_d = GET_B;
        end
        default: begin
          state_d = GET_A;
          valid_d = 1'b0;
        end
      endcase
    end
  end

  assign entry_state = state_q;

endmodule

// File: tb/tb_calc_operand_loader.sv
// Self-checking bench for calc_operand_loader with a behavioural model that
// follows the block's rules edge by edge (input delays, stable-run debounce,
// press detection, operand entry sequence).
module tb_calc_operand_loader;

  localparam int W  = 8;
  localparam int DB = 4;
`ifdef CALC_DEBOUNCE_EN
  localparam bit DB_MODE = 1'b1;
`else
  localparam bit DB_MODE = 1'b0;
`endif
  localparam int LAT = DB_MODE ? (2 + DB) : 2;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] sw = '0;
  logic         btn_enter = 1'b0;
  logic         btn_clear = 1'b0;
  logic [W-1:0] a, b;
  logic         operands_valid;
  logic [1:0]   entry_state;

  int checks = 0;
  int errors = 0;

  calc_operand_loader #(.WIDTH(W), .DEBOUNCE_CYCLES(DB)) dut (
    .clk(clk), .rst(rst), .sw(sw), .btn_enter(btn_enter), .btn_clear(btn_clear),
    .a(a), .b(b), .operands_valid(operands_valid), .entry_state(entry_state)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  bit           m_e[2];      // enter samples, [1] is the older
  bit           m_c[2];
  logic [W-1:0] m_s[2];
  bit           m_lvl;       // accepted enter level
  bit           m_lvl_prev;  // accepted level one edge earlier
  int           m_run;       // consecutive edges the sampled level disagreed
  logic [1:0]   m_st;
  logic [W-1:0] m_a, m_b;

  function automatic logic [2*W+2:0] exp_bus();
    return {m_a, m_b, (m_st == 2'b10), m_st};
  endfunction

  task automatic model_edge();
    bit es, cs, lcur;
    logic [W-1:0] ss;
    if (rst) begin
      m_e = '{0, 0}; m_c = '{0, 0}; m_s = '{'0, '0};
      m_lvl = 0; m_lvl_prev = 0; m_run = 0;
      m_st = 2'b00; m_a = '0; m_b = '0;
      return;
    end
    es = m_e[1]; cs = m_c[1]; ss = m_s[1];
    lcur = DB_MODE ? m_lvl : es;
    if (cs) begin
      m_st = 2'b00; m_a = '0; m_b = '0;
    end else if (lcur && !m_lvl_prev) begin
      if (m_st == 2'b00)      begin m_a = ss; m_st = 2'b01; end
      else if (m_st == 2'b01) begin m_b = ss; m_st = 2'b10; end
      else                    begin m_a = ss; m_st = 2'b01; end
    end
    m_lvl_prev = lcur;
    if (es != m_lvl) begin
      m_run++;
      if (m_run >= DB) begin m_lvl = es; m_run = 0; end
    end else m_run = 0;
    m_e[1] = m_e[0]; m_e[0] = btn_enter;
    m_c[1] = m_c[0]; m_c[0] = btn_clear;
    m_s[1] = m_s[0]; m_s[0] = sw;
  endtask

  // Advance one edge; outputs are examined 1 ns later.
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) step();
    checks++;
    if ({a, b, operands_valid, entry_state} !== '0) begin
      errors++;
      $display("FAIL reset got a=%h b=%h v=%b st=%b exp all zero", a, b, operands_valid, entry_state);
    end
    rst = 1'b0;
    step();
    checks++;
    if ({a, b, operands_valid, entry_state} !== '0) begin
      errors++;
      $display("FAIL reset_release got a=%h b=%h v=%b st=%b exp all zero", a, b, operands_valid, entry_state);
    end
  endtask

  task automatic test_basic_load();
    sw = 8'h01; btn_enter = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      if (i == LAT - 1) begin
        checks++;
        if (entry_state !== 2'b00 || a !== 8'h00) begin
          errors++;
          $display("FAIL load_a_early edge k+%0d st=%b a=%h exp 00/00", i, entry_state, a);
        end
      end
      if (i == LAT) begin
        checks++;
        if (entry_state !== 2'b01 || a !== 8'h01 || b !== 8'h00 || operands_valid !== 1'b0) begin
          errors++;
          $display("FAIL load_a edge k+%0d st=%b a=%h b=%h v=%b exp 01/01/00/0", i, entry_state, a, b, operands_valid);
        end
      end
    end
    btn_enter = 1'b0;
    repeat (10) step();
    sw = 8'h05; btn_enter = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      if (i == LAT) begin
        checks++;
        if (entry_state !== 2'b10 || a !== 8'h01 || b !== 8'h05 || operands_valid !== 1'b1) begin
          errors++;
          $display("FAIL load_b edge k+%0d st=%b a=%h b=%h v=%b exp 10/01/05/1", i, entry_state, a, b, operands_valid);
        end
      end
    end
    btn_enter = 1'b0;
    repeat (10) step();
    checks++;
    if ({a, b, operands_valid, entry_state} !== exp_bus()) begin
      errors++;
      $display("FAIL basic_model got %h exp %h", {a, b, operands_valid, entry_state}, exp_bus());
    end
  endtask

  task automatic test_reentry();
    sw = 8'hFF; btn_enter = 1'b1;
    repeat (10) step();
    btn_enter = 1'b0;
    repeat (10) step();
    checks++;
    if (entry_state !== 2'b01 || a !== 8'hFF || b !== 8'h05 || operands_valid !== 1'b0) begin
      errors++;
      $display("FAIL reentry st=%b a=%h b=%h v=%b exp 01/ff/05/0", entry_state, a, b, operands_valid);
    end
  endtask

  task automatic test_bounce();
    int dut_tr, mdl_tr;
    logic [1:0] dut_prev, mdl_prev;
    dut_tr = 0; mdl_tr = 0;
    dut_prev = entry_state; mdl_prev = m_st;
    sw = 8'h3C;
    for (int n = 0; n < 38; n++) begin
      btn_enter = (n < 16) ? ((n % 4) != 3) : (n < 28);
      step();
      if (entry_state !== dut_prev) dut_tr++;
      if (m_st != mdl_prev) mdl_tr++;
      dut_prev = entry_state; mdl_prev = m_st;
      checks++;
      if ({a, b, operands_valid, entry_state} !== exp_bus()) begin
        errors++;
        $display("FAIL bounce_cycle n=%0d got %h exp %h", n, {a, b, operands_valid, entry_state}, exp_bus());
      end
    end
    checks++;
    if (dut_tr != mdl_tr) begin
      errors++;
      $display("FAIL bounce_transitions got %0d exp %0d", dut_tr, mdl_tr);
    end
  endtask

  task automatic test_held();
    int tr;
    logic [1:0] prev;
    btn_clear = 1'b1;
    repeat (4) step();
    btn_clear = 1'b0;
    repeat (3) step();
    checks++;
    if (entry_state !== 2'b00 || a !== '0 || b !== '0) begin
      errors++;
      $display("FAIL held_clear st=%b a=%h b=%h exp 00/00/00", entry_state, a, b);
    end
    tr = 0; prev = entry_state;
    sw = 8'h77; btn_enter = 1'b1;
    repeat (50) begin
      step();
      if (entry_state !== prev) tr++;
      prev = entry_state;
    end
    btn_enter = 1'b0;
    repeat (10) begin
      step();
      if (entry_state !== prev) tr++;
      prev = entry_state;
    end
    checks++;
    if (tr != 1 || entry_state !== 2'b01 || a !== 8'h77 || b !== m_b) begin
      errors++;
      $display("FAIL held transitions=%0d st=%b a=%h b=%h exp 1/01/77/%h", tr, entry_state, a, b, m_b);
    end
  endtask

  task automatic test_clear_priority();
    // Now in GET_B; time clear so clear_s lands on the pulse edge.
    sw = 8'h99; btn_enter = 1'b1;
    for (int i = 0; i <= LAT; i++) begin
      if (i == LAT - 2) btn_clear = 1'b1;
      step();
    end
    checks++;
    if (entry_state !== 2'b00 || a !== '0 || b !== '0 || operands_valid !== 1'b0) begin
      errors++;
      $display("FAIL clear_priority st=%b a=%h b=%h v=%b exp 00/00/00/0", entry_state, a, b, operands_valid);
    end
    repeat (5) step();
    checks++;
    if (entry_state !== 2'b00) begin
      errors++;
      $display("FAIL clear_hold st=%b exp 00", entry_state);
    end
    btn_clear = 1'b0; btn_enter = 1'b0;
    repeat (10) step();
    // Reset while a press is being counted.
    sw = 8'h42; btn_enter = 1'b1;
    repeat (3) step();
    rst = 1'b1;
    step();
    checks++;
    if ({a, b, operands_valid, entry_state} !== '0) begin
      errors++;
      $display("FAIL rst_mid got a=%h b=%h v=%b st=%b exp all zero", a, b, operands_valid, entry_state);
    end
    rst = 1'b0;
    for (int n = 0; n < 14; n++) begin
      step();
      checks++;
      if ({a, b, operands_valid, entry_state} !== exp_bus()) begin
        errors++;
        $display("FAIL rst_recover n=%0d got %h exp %h", n, {a, b, operands_valid, entry_state}, exp_bus());
      end
    end
    btn_enter = 1'b0;
    repeat (10) step();
  endtask

  task automatic test_random();
    int run_left;
    run_left = 0;
    for (int n = 0; n < 600; n++) begin
      if (run_left == 0) begin
        btn_enter = $urandom_range(0, 1);
        run_left  = $urandom_range(1, 12);
      end
      run_left--;
      btn_clear = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 4) == 0) sw = W'($urandom);
      step();
      checks++;
      if ({a, b, operands_valid, entry_state} !== exp_bus()) begin
        errors++;
        $display("FAIL random n=%0d got %h exp %h", n, {a, b, operands_valid, entry_state}, exp_bus());
      end
    end
    btn_enter = 1'b0; btn_clear = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic_load();
    test_reentry();
    test_bounce();
    test_held();
    test_clear_priority();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
